// File: rtl/can_rx_destuffer.sv
// can_rx_destuffer: CAN receive bit-stream stage; idle/SOF tracking, destuffing, stuff-error detection and CRC-15.
// Ports:
//   GCLK, RES (async active-low) ; bit_in/bit_stb sampled bus bit and its strobe
//   stuff_en (destuff + CRC active), frame_abort (return to WAIT_IDLE)
//   rx_bit/rx_stb destuffed bit stream, sof pulse, bus_idle level, stuff_err pulse
//   crc running CRC-15, crc_ok (crc == 0), bit_cnt emitted bits since SOF (saturating)
module can_rx_destuffer #(
    parameter int IDLE_BITS = 11,
    parameter int STUFF_LEN = 5
) (
    input  logic        GCLK,
    input  logic        RES,
    input  logic        bit_in,
    input  logic        bit_stb,
    input  logic        stuff_en,
    input  logic        frame_abort,
    output logic        rx_bit,
    output logic        rx_stb,
    output logic        sof,
    output logic        bus_idle,
    output logic        stuff_err,
    output logic [14:0] crc,
    output logic        crc_ok,
    output logic [7:0]  bit_cnt
);
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam logic [IW-1:0] IDLE_TOP = IW'(IDLE_BITS - 1);
    localparam logic [3:0] RUN_TOP = 4'(STUFF_LEN);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, FRAME} state_t;

    state_t state, state_nx;
    logic [IW-1:0] idle_cnt, idle_nx;
    logic [3:0] run, run_nx;
    logic last, last_nx, bit_nx, stb_nx, sof_nx, err_nx;
    logic [14:0] crc_nx;
    logic [7:0] cnt_nx;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0);
    endfunction

    assign bus_idle = (state == IDLE);
    assign crc_ok = (crc == 15'h0);

    always_comb begin
        state_nx = state;
        idle_nx = idle_cnt;
        run_nx = run;
        last_nx = last;
        crc_nx = crc;
        cnt_nx = bit_cnt;
        bit_nx = rx_bit;
        stb_nx = 1'b0;
        sof_nx = 1'b0;
        err_nx = 1'b0;
        // Abort takes precedence and swallows any coincident bit.
        if (state == FRAME && frame_abort) begin
            state_nx = WAIT_IDLE;
            idle_nx = '0;
        end else if (bit_stb) begin
            case (state)
                WAIT_IDLE: begin
                    idle_nx = bit_in ? idle_cnt + 1'b1 : '0;
                    if (bit_in && idle_cnt == IDLE_TOP) begin
                        state_nx = IDLE;
                        idle_nx = '0;
                    end
                end
                IDLE: if (!bit_in) begin
                    state_nx = FRAME;
                    stb_nx = 1'b1;
                    sof_nx = 1'b1;
                    bit_nx = 1'b0;
                    crc_nx = '0;
                    last_nx = 1'b0;
                    run_nx = 4'd1;
                    cnt_nx = 8'd1;
                end
                FRAME: if (stuff_en && run == RUN_TOP) begin
                    if (bit_in == last) begin
                        err_nx = 1'b1;
                        state_nx = WAIT_IDLE;
                        idle_nx = '0;
                    end else begin
                        last_nx = bit_in;
                        run_nx = 4'd1;
                    end
                end else begin
                    stb_nx = 1'b1;
                    bit_nx = bit_in;
                    cnt_nx = (bit_cnt == 8'hFF) ? bit_cnt : bit_cnt + 8'd1;
                    // run keeps tracking with stuffing off; saturate so it cannot wrap.
                    run_nx = (bit_in == last) ? ((run == 4'hF) ? run : run + 4'd1) : 4'd1;
                    last_nx = bit_in;
                    crc_nx = stuff_en ? crc_step(crc, bit_in) : crc;
                end
                default: state_nx = WAIT_IDLE;
            endcase
        end
    end

    always_ff @(posedge GCLK or negedge RES) begin
        if (!RES) begin
            state <= WAIT_IDLE;
            idle_cnt <= '0;
            run <= '0;
            last <= 1'b1;
            crc <= '0;
            bit_cnt <= '0;
            rx_bit <= 1'b0;
            rx_stb <= 1'b0;
            sof <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            state <= state_nx;
            idle_cnt <= idle_nx;
            run <= run_nx;
            last <= last_nx;
            crc <= crc_nx;
            bit_cnt <= cnt_nx;
            rx_bit <= bit_nx;
            rx_stb <= stb_nx;
            sof <= sof_nx;
            stuff_err <= err_nx;
        end
    end
endmodule

// File: tb/tb_can_rx_destuffer.sv
// tb_can_rx_destuffer: scoreboard bench for can_rx_destuffer with a polynomial-division CRC reference.
module tb_can_rx_destuffer;
    logic GCLK = 1'b0;
    logic RES = 1'b0;
    logic bit_in = 1'b1, bit_stb = 1'b0, stuff_en = 1'b1, frame_abort = 1'b0;
    logic rx_bit, rx_stb, sof, bus_idle, stuff_err, crc_ok;
    logic [14:0] crc;
    logic [7:0] bit_cnt;
    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [26:0] v;
    } exp_t;
    exp_t q[$];

    can_rx_destuffer dut (
        .GCLK(GCLK), .RES(RES), .bit_in(bit_in), .bit_stb(bit_stb), .stuff_en(stuff_en),
        .frame_abort(frame_abort), .rx_bit(rx_bit), .rx_stb(rx_stb), .sof(sof),
        .bus_idle(bus_idle), .stuff_err(stuff_err), .crc(crc), .crc_ok(crc_ok), .bit_cnt(bit_cnt)
    );

    always #5 GCLK = ~GCLK;

    always @(negedge GCLK) begin
        if (RES && (rx_stb || stuff_err)) begin
            checks++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_output: got stb=%b bit=%b sof=%b err=%b crc=%h cnt=%0d, required none",
                         rx_stb, rx_bit, sof, stuff_err, crc, bit_cnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({rx_stb, rx_bit, sof, stuff_err, crc, bit_cnt} !== e.v) begin
                    errs++;
                    $display("FAIL output_item: got {stb,bit,sof,err,crc,cnt}=%h required %h",
                             {rx_stb, rx_bit, sof, stuff_err, crc, bit_cnt}, e.v);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic push(input logic b, input logic s, input logic e, input logic [14:0] c, input logic [7:0] n);
        exp_t x;
        x.v = {!e, b, s, e, c, n};
        q.push_back(x);
    endtask

    task automatic strobe(input logic b, input logic en, input logic ab);
        @(negedge GCLK);
        bit_in = b;
        stuff_en = en;
        frame_abort = ab;
        bit_stb = 1'b1;
        @(negedge GCLK);
        bit_stb = 1'b0;
        frame_abort = 1'b0;
        @(negedge GCLK);
    endtask

    task automatic recessive(input int n);
        repeat (n) strobe(1'b1, 1'b1, 1'b0);
    endtask

    task automatic abort_only();
        @(negedge GCLK);
        frame_abort = 1'b1;
        @(negedge GCLK);
        frame_abort = 1'b0;
    endtask

    // Remainder of M(x)*x^15 mod (x^15 + 0x4599) over the first n message bits, by long division.
    function automatic logic [14:0] crc_rem(input bit m[$], input int n);
        bit a[$];
        logic [15:0] g;
        logic [14:0] r;
        g = 16'hC599;
        for (int i = 0; i < n; i++) a.push_back(m[i]);
        repeat (15) a.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (a[i]) for (int j = 0; j < 16; j++) a[i+j] = a[i+j] ^ g[15-j];
        for (int j = 0; j < 15; j++) r[14-j] = a[n+j];
        return r;
    endfunction

    task automatic run_frame(input int len, input bit flip);
        bit lb[$];
        bit le[$];
        bit raw[$];
        bit ren[$];
        logic [14:0] c;
        int nen, fp, run;
        bit last, b;
        lb.push_back(1'b0);
        le.push_back(1'b1);
        for (int i = 0; i < len; i++) begin
            b = (i == 0) ? bit'($urandom_range(0, 1))
                         : (($urandom_range(0, 3) == 0) ? !lb[lb.size()-1] : lb[lb.size()-1]);
            lb.push_back(b);
            le.push_back(1'b1);
        end
        c = crc_rem(lb, lb.size());
        if (flip) begin
            fp = $urandom_range(1, len);
            lb[fp] = !lb[fp];
        end
        for (int i = 14; i >= 0; i--) begin
            lb.push_back(c[i]);
            le.push_back(1'b1);
        end
        nen = lb.size();
        for (int i = 0; i < 8; i++) begin
            lb.push_back(1'b1);
            le.push_back(1'b0);
        end
        for (int k = 0; k < lb.size(); k++)
            push(lb[k], k == 0, 1'b0, crc_rem(lb, (k < nen) ? k + 1 : nen), (k >= 254) ? 8'd255 : 8'(k + 1));
        run = 0;
        last = 1'b1;
        for (int k = 0; k < lb.size(); k++) begin
            raw.push_back(lb[k]);
            ren.push_back(le[k]);
            run = (lb[k] == last) ? run + 1 : 1;
            last = lb[k];
            if (le[k] && run == 5) begin
                raw.push_back(!last);
                ren.push_back(1'b1);
                last = !last;
                run = 1;
            end
        end
        for (int i = 0; i < raw.size(); i++) strobe(raw[i], ren[i], 1'b0);
        chk(flip ? "crc_ok_flipped" : "crc_ok_clean", {15'h0, crc_ok}, {15'h0, crc_rem(lb, nen) == 15'h0});
        abort_only();
        stuff_en = 1'b1;
        recessive(11);
    endtask

    initial begin
        repeat (2) @(negedge GCLK);
        chk("rst_rx_stb", {15'h0, rx_stb}, 16'h0);
        chk("rst_rx_bit", {15'h0, rx_bit}, 16'h0);
        chk("rst_sof", {15'h0, sof}, 16'h0);
        chk("rst_stuff_err", {15'h0, stuff_err}, 16'h0);
        chk("rst_bus_idle", {15'h0, bus_idle}, 16'h0);
        chk("rst_crc", {1'b0, crc}, 16'h0);
        chk("rst_crc_ok", {15'h0, crc_ok}, 16'h1);
        chk("rst_bit_cnt", {8'h0, bit_cnt}, 16'h0);
        RES = 1'b1;

        recessive(10);
        strobe(1'b0, 1'b1, 1'b0);
        recessive(10);
        chk("idle_interrupted", {15'h0, bus_idle}, 16'h0);
        recessive(1);
        chk("idle_after_11", {15'h0, bus_idle}, 16'h1);

        push(1'b0, 1'b1, 1'b0, 15'h0, 8'd1);
        push(1'b1, 1'b0, 1'b0, 15'h4599, 8'd2);
        push(1'b0, 1'b0, 1'b0, 15'h4EAB, 8'd3);
        strobe(1'b0, 1'b1, 1'b0);
        chk("idle_falls_after_sof", {15'h0, bus_idle}, 16'h0);
        strobe(1'b1, 1'b1, 1'b0);
        strobe(1'b0, 1'b1, 1'b0);
        chk("cnt_3", {8'h0, bit_cnt}, 16'd3);
        strobe(1'b1, 1'b1, 1'b1);
        chk("abort_cnt_hold", {8'h0, bit_cnt}, 16'd3);
        chk("abort_crc_hold", {1'b0, crc}, 16'h4EAB);
        strobe(1'b0, 1'b1, 1'b0);
        chk("abort_no_idle", {15'h0, bus_idle}, 16'h0);
        recessive(11);
        chk("abort_reidle", {15'h0, bus_idle}, 16'h1);

        for (int k = 0; k < 5; k++) push(1'b0, k == 0, 1'b0, 15'h0, 8'(k + 1));
        push(1'b0, 1'b0, 1'b0, 15'h0, 8'd6);
        repeat (5) strobe(1'b0, 1'b1, 1'b0);
        strobe(1'b1, 1'b1, 1'b0);
        strobe(1'b0, 1'b1, 1'b0);
        chk("destuff_cnt_6", {8'h0, bit_cnt}, 16'd6);
        abort_only();
        recessive(11);

        for (int k = 0; k < 5; k++) push(1'b0, k == 0, 1'b0, 15'h0, 8'(k + 1));
        push(1'b0, 1'b0, 1'b1, 15'h0, 8'd5);
        repeat (6) strobe(1'b0, 1'b1, 1'b0);
        chk("stuff_err_state", {15'h0, bus_idle}, 16'h0);
        recessive(10);
        strobe(1'b0, 1'b1, 1'b0);
        recessive(10);
        chk("err_need_11", {15'h0, bus_idle}, 16'h0);
        recessive(1);
        chk("err_reidle", {15'h0, bus_idle}, 16'h1);

        for (int f = 0; f < 6; f++) run_frame($urandom_range(8, 60), f[0]);
        run_frame(300, 1'b0);

        push(1'b0, 1'b1, 1'b0, 15'h0, 8'd1);
        strobe(1'b0, 1'b1, 1'b0);
        @(negedge GCLK);
        bit_in = 1'b1;
        bit_stb = 1'b1;
        @(posedge GCLK);
        #1;
        chk("pre_reset_rx_stb", {15'h0, rx_stb}, 16'h1);
        RES = 1'b0;
        bit_stb = 1'b0;
        #1;
        chk("midrst_rx_stb", {15'h0, rx_stb}, 16'h0);
        chk("midrst_crc", {1'b0, crc}, 16'h0);
        chk("midrst_crc_ok", {15'h0, crc_ok}, 16'h1);
        chk("midrst_bit_cnt", {8'h0, bit_cnt}, 16'h0);
        chk("midrst_rx_bit", {15'h0, rx_bit}, 16'h0);
        @(negedge GCLK);
        RES = 1'b1;
        recessive(10);
        strobe(1'b0, 1'b1, 1'b0);
        recessive(11);
        chk("rst_reidle", {15'h0, bus_idle}, 16'h1);
        push(1'b0, 1'b1, 1'b0, 15'h0, 8'd1);
        strobe(1'b0, 1'b1, 1'b0);

        repeat (5) @(negedge GCLK);
        chk("queue_drained", 16'(q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/can_rx_destuffer.md
# can_rx_destuffer

Receive-side bit-stream stage placed directly downstream of the CAN bit sampler. It consumes one sampled bus bit per bit time, tracks bus idle and start-of-frame, and removes stuff bits. It flags stuff errors and accumulates the CRC-15 over the destuffed stream. Its output is a clean, strobed bit stream plus CRC status for the frame decoder.

## Interface
- IDLE_BITS, 11, consecutive recessive bits required to declare bus idle
- STUFF_LEN, 5, equal consecutive bits after which a stuff bit is expected
- GCLK  in  1  main clock; all state changes on rising edge
- RES  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- bit_in  in  1  sampled bus level (1 = recessive, 0 = dominant); valid only with bit_stb
- bit_stb  in  1  one-cycle strobe, one per bit time, from the sampler's sample point
- stuff_en  in  1  from frame decoder: 1 = destuff and CRC-update active; 0 from CRC delimiter onward
- frame_abort  in  1  from frame decoder: end/abandon frame, return to WAIT_IDLE
- rx_bit  out  1  destuffed bit value; valid with rx_stb
- rx_stb  out  1  one-cycle strobe per emitted (non-stuff) bit
- sof  out  1  one-cycle pulse coincident with rx_stb of the SOF bit
- bus_idle  out  1  level, high while in IDLE
- stuff_err  out  1  one-cycle pulse on stuff violation
- crc  out  15  running CRC register
- crc_ok  out  1  level, crc == 0
- bit_cnt  out  8  emitted bits since SOF including SOF, saturates at 255

## Operation
- States: WAIT_IDLE, IDLE, FRAME. Reset enters WAIT_IDLE with idle_cnt=0.
- All state and outputs update only on GCLK edges where bit_stb=1, except pulse outputs, which clear on the next cycle.
- WAIT_IDLE: on a recessive bit, idle_cnt+1; on a dominant bit, idle_cnt=0. When idle_cnt reaches IDLE_BITS, move to IDLE and clear idle_cnt. No rx_stb is issued.
- IDLE: bus_idle=1. A recessive bit produces no action. A dominant bit is SOF:
  - emit rx_bit=0, rx_stb=1, sof=1;
  - load crc from 0 and update it with the bit, giving crc=0;
  - set last=0, run=1, bit_cnt=1;
  - move to FRAME.
- FRAME, stuff_en=1, run==STUFF_LEN:
  - If bit_in==last: pulse stuff_err, move to WAIT_IDLE with idle_cnt=0, no rx_stb.
  - Otherwise the bit is a stuff bit: discard it, set last=bit_in, run=1, no rx_stb, no CRC update, bit_cnt unchanged.
- FRAME, other bits: emit rx_bit=bit_in with rx_stb, and bit_cnt+1 (saturating).
  - If bit_in==last, run+1; otherwise run=1. Then set last=bit_in.
  - If stuff_en=1, update the CRC.
- FRAME, stuff_en=0: no stuff check. run and last keep tracking. crc is frozen.
- CRC update, applied when permitted: nxt = bit ^ crc[14]; crc = {crc[13:0],1'b0}; if nxt, crc ^= 15'h4599.
- frame_abort=1, any cycle in FRAME: move to WAIT_IDLE with idle_cnt=0. crc and bit_cnt hold until the next SOF.
- frame_abort together with bit_stb in the same cycle: abort wins. The bit is discarded entirely, with no emit, no idle count and no error.
- frame_abort in WAIT_IDLE or IDLE is ignored.

## Timing
- Registered outputs: rx_stb, rx_bit, sof, stuff_err, crc, crc_ok and bit_cnt are valid one GCLK cycle after the bit_stb edge.
- bus_idle rises one cycle after the IDLE_BITS-th recessive strobe. It falls one cycle after the SOF strobe.
- Reset values: state=WAIT_IDLE; rx_bit, rx_stb, sof and stuff_err are 0; bus_idle=0; crc=0; crc_ok=1; bit_cnt=0; run=0; last=1; idle_cnt=0.
- Asserting RES mid-frame aborts immediately, with no pulse outputs. After release, IDLE_BITS recessive bits are required again before a SOF is accepted.
- Any two bit_stb pulses are at least 2 cycles apart. Back-to-back strobes are not required to be supported.

## Test plan
- Reset, then 11 recessive strobes -> bus_idle=1 one cycle after the 11th. With 10 recessive, 1 dominant, 10 recessive -> bus_idle stays 0.
- From IDLE, bits 0,1 -> sof with rx_bit=0, then rx_bit=1; crc=15'h4599; bit_cnt=2. A further 0 -> crc=15'h4EAB, bit_cnt=3.
- From IDLE, bits 0,0,0,0,0,1,0 -> five rx_stb of 0, the stuff 1 dropped, sixth rx_stb carries 0; bit_cnt=6.
- From IDLE, six consecutive dominant bits -> five rx_stb, stuff_err pulse on the 6th, state WAIT_IDLE. The next SOF is accepted only after 11 recessive bits.
- Random frame payload, then its CRC MSB-first (stuffed), then stuff_en=0 -> crc_ok=1. Repeat with one payload bit flipped -> crc_ok=0.
- frame_abort coincident with a bit_stb mid-frame -> no rx_stb, state WAIT_IDLE. RES low mid-frame -> all outputs at reset values within the same cycle.
